input_port_arbiter: RTL and testbench

//  Packet-granular arbiter merging NUM_PORTS 256-bit AXI-Stream inputs into one output.

---
 rtl/input_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_input_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_arbiter.sv
// input_port_arbiter
// Packet-granular arbiter that merges NUM_PORTS AXI-Stream inputs into one
// registered output stream. Ports whose width converter raises must_read are
// served first; otherwise ports are served round-robin. The grant is held for
// a whole packet, so beats of different packets never interleave.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no grant; all s_axis_tready low; pick a winner if any is valid
// ST_FORWARD | grant locked to one port until its tlast beat is accepted
module input_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = 2
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]              s_axis_tlast,
  output logic [NUM_PORTS-1:0]              s_axis_tready,
  input  logic [NUM_PORTS-1:0]              must_read,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic [USER_WIDTH-1:0]             m_axis_tuser,
  output logic [ID_WIDTH-1:0]               m_axis_tid,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_FORWARD = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ID_WIDTH-1:0]   r_grant;
  logic [ID_WIDTH-1:0]   w_grant_nxt;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   w_rr_ptr_nxt;

  logic [NUM_PORTS-1:0]  w_urgent;
  logic [NUM_PORTS-1:0]  w_cand;
  logic [ID_WIDTH-1:0]   w_winner;
  logic                  w_found;

  logic                  w_out_free;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KEEP_WIDTH-1:0] w_sel_keep;
  logic [USER_WIDTH-1:0] w_sel_user;
  logic                  w_sel_last;

  // Winner search: urgent valid ports mask out the rest; a must_read without
  // tvalid contributes nothing. Scan starts at rr_ptr and wraps.
  always_comb begin
    w_urgent = s_axis_tvalid & must_read;
    w_cand   = (|w_urgent) ? w_urgent : s_axis_tvalid;
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && w_cand[(int'(r_rr_ptr) + i) % NUM_PORTS]) begin
        w_found  = 1'b1;
        w_winner = ID_WIDTH'((int'(r_rr_ptr) + i) % NUM_PORTS);
      end
    end
  end

  // Granted-port beat select and handshake; the output stage can take a beat
  // when it is empty or being drained this cycle.
  always_comb begin
    w_sel_data    = s_axis_tdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    w_sel_keep    = s_axis_tkeep[int'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
    w_sel_user    = s_axis_tuser[int'(r_grant)*USER_WIDTH +: USER_WIDTH];
    w_sel_last    = s_axis_tlast[r_grant];
    w_out_free    = m_axis_tready | ~m_axis_tvalid;
    s_axis_tready = '0;
    if (r_state == ST_FORWARD) begin
      s_axis_tready[r_grant] = w_out_free;
    end
    w_accept = (r_state == ST_FORWARD) & s_axis_tvalid[r_grant] & w_out_free;
  end

  // Next-state, grant and round-robin pointer.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt  = ST_FORWARD;
          w_grant_nxt  = w_winner;
          w_rr_ptr_nxt = (w_winner == ID_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                 : w_winner + ID_WIDTH'(1);
        end
      end
      ST_FORWARD: begin
        if (w_accept && w_sel_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM, grant and pointer registers.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Single full-throughput output stage: load on accept, hold while stalled,
  // go empty when drained with nothing new behind it.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tid    <= '0;
    end else if (w_accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= w_sel_last;
      m_axis_tdata  <= w_sel_data;
      m_axis_tkeep  <= w_sel_keep;
      m_axis_tuser  <= w_sel_user;
      m_axis_tid    <= r_grant;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_port_arbiter.sv
// Directed bench for input_port_arbiter: per-port beat tables feed the
// inputs, accepted output beats are captured and compared against
// hand-written expected sequences.
module tb_input_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 1;
  localparam int IW = 2;
  localparam logic [KW-1:0] KEEP_ALL = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP*UW-1:0] s_tuser;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tready;
  logic [NP-1:0]    must_read;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [UW-1:0]    m_tuser;
  logic [IW-1:0]    m_tid;
  logic             m_tvalid;
  logic             m_tlast;
  logic             m_tready;

  input_port_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW)
  ) dut (
    .axi_aclk      (clk),
    .axi_reset     (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .must_read     (must_read),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tid    (m_tid),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [DW-1:0] src_d [NP][16];
  logic [KW-1:0] src_k [NP][16];
  logic          src_l [NP][16];
  int            src_n [NP];
  int            src_i [NP];
  logic [NP-1:0] gap;

  logic [DW-1:0] out_d   [64];
  logic [KW-1:0] out_k   [64];
  logic [UW-1:0] out_u   [64];
  logic [IW-1:0] out_id  [64];
  logic          out_l   [64];
  int            out_cyc [64];
  int            out_n;

  logic          stalled;
  logic [DW-1:0] prev_d;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (src_i[p] < src_n[p] && !gap[p]) begin
        s_tvalid[p]          = 1'b1;
        s_tdata[p*DW +: DW]  = src_d[p][src_i[p]];
        s_tkeep[p*KW +: KW]  = src_k[p][src_i[p]];
        s_tuser[p]           = src_d[p][src_i[p]][0];
        s_tlast[p]           = src_l[p][src_i[p]];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
      end
    end
    #1;
  endtask

  task automatic tick();
    logic [NP-1:0] acc;
    #1;
    acc = s_tvalid & s_tready;
    if (m_tvalid && m_tready && out_n < 64) begin
      out_d[out_n]   = m_tdata;
      out_k[out_n]   = m_tkeep;
      out_u[out_n]   = m_tuser;
      out_id[out_n]  = m_tid;
      out_l[out_n]   = m_tlast;
      out_cyc[out_n] = cyc;
      out_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) if (acc[p]) src_i[p]++;
    drive();
  endtask

  task automatic add_beat(input int p, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    src_d[p][src_n[p]] = d;
    src_k[p][src_n[p]] = k;
    src_l[p][src_n[p]] = l;
    src_n[p]++;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin
      src_n[p] = 0;
      src_i[p] = 0;
    end
    out_n = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    gap       = '0;
    must_read = '0;
    clear_all();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    m_tready  = 1'b0;
    must_read = '0;
    gap       = '0;
    s_tdata   = '0;
    s_tkeep   = '0;
    s_tuser   = '0;
    s_tvalid  = '0;
    s_tlast   = '0;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();

    // reset state
    check("rst_mvalid", m_tvalid, 0);
    check("rst_mlast",  m_tlast, 0);
    check("rst_mdata",  m_tdata, 0);
    check("rst_mtid",   m_tid, 0);
    check("rst_sready", s_tready, 0);

    // 1: port 1, 3-beat packet, latency and contents
    m_tready = 1'b1;
    add_beat(1, 1, KEEP_ALL, 1'b0);
    add_beat(1, 2, KEEP_ALL, 1'b0);
    add_beat(1, 3, 32'h0000_000F, 1'b1);
    drive();
    check("t1_idle_sready", s_tready, 0);
    tick();
    check("t1_sready_t1", s_tready, 4'b0010);
    check("t1_mvalid_t1", m_tvalid, 0);
    tick();
    check("t1_mvalid_t2", m_tvalid, 1);
    check("t1_tid_t2",    m_tid, 1);
    check("t1_data_t2",   m_tdata, 1);
    for (int c = 0; c < 10 && out_n < 3; c++) tick();
    check("t1_count", out_n, 3);
    check("t1_drain_mvalid", m_tvalid, 0);
    check("t1_drain_sready", s_tready, 0);
    for (int i = 0; i < 3; i++) begin
      check("t1_data", out_d[i], i + 1);
      check("t1_tid",  out_id[i], 1);
      check("t1_last", out_l[i], (i == 2) ? 1 : 0);
      check("t1_keep", out_k[i], (i == 2) ? 32'h0000_000F : KEEP_ALL);
      check("t1_user", out_u[i], (i == 1) ? 0 : 1);
    end

    // 2: all ports, back-to-back single-beat packets, round robin
    do_reset();
    m_tready = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++)
        add_beat(p, 8'h10 * (p + 1) + k, KEEP_ALL, 1'b1);
    drive();
    for (int c = 0; c < 40 && out_n < 6; c++) tick();
    check("t2_count", (out_n >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6; i++) begin
      check("t2_tid",  out_id[i], i % 4);
      check("t2_data", out_d[i], 8'h10 * ((i % 4) + 1) + i / 4);
      check("t2_last", out_l[i], 1);
      if (i > 0) check("t2_spacing", out_cyc[i] - out_cyc[i-1], 2);
    end

    // 3: must_read on port 2 overrides round robin from port 0
    do_reset();
    m_tready  = 1'b1;
    must_read = 4'b0100;
    add_beat(0, 8'hA1, KEEP_ALL, 1'b0);
    add_beat(0, 8'hA2, KEEP_ALL, 1'b1);
    add_beat(2, 8'hC1, KEEP_ALL, 1'b0);
    add_beat(2, 8'hC2, KEEP_ALL, 1'b1);
    drive();
    for (int c = 0; c < 30 && out_n < 4; c++) tick();
    check("t3_count", out_n, 4);
    check("t3_tid0",  out_id[0], 2);
    check("t3_data0", out_d[0], 8'hC1);
    check("t3_tid1",  out_id[1], 2);
    check("t3_data1", out_d[1], 8'hC2);
    check("t3_last1", out_l[1], 1);
    check("t3_tid2",  out_id[2], 0);
    check("t3_data2", out_d[2], 8'hA1);
    check("t3_tid3",  out_id[3], 0);
    check("t3_data3", out_d[3], 8'hA2);

    // 4: 8-beat packet on port 3 with toggling downstream ready and an
    // input gap mid-packet; port 0 waits and must not interleave
    must_read = '0;
    out_n     = 0;
    for (int k = 0; k < 8; k++) add_beat(3, 8'h30 + k, KEEP_ALL, (k == 7));
    add_beat(0, 8'h0F, KEEP_ALL, 1'b1);
    drive();
    for (int c = 0; c < 80 && out_n < 9; c++) begin
      m_tready = (c % 2 == 0);
      gap[3]   = (c >= 6 && c < 9);
      stalled  = m_tvalid & ~m_tready;
      prev_d   = m_tdata;
      tick();
      if (stalled) begin
        check("t4_hold_valid", m_tvalid, 1);
        check("t4_hold_data",  m_tdata, prev_d);
      end
    end
    gap      = '0;
    m_tready = 1'b1;
    check("t4_count", out_n, 9);
    for (int i = 0; i < 8; i++) begin
      check("t4_data", out_d[i], 8'h30 + i);
      check("t4_tid",  out_id[i], 3);
      check("t4_last", out_l[i], (i == 7) ? 1 : 0);
    end
    check("t4_wait_tid",  out_id[8], 0);
    check("t4_wait_data", out_d[8], 8'h0F);

    // 5: reset in the middle of a 4-beat packet on port 1
    do_reset();
    m_tready = 1'b1;
    for (int k = 0; k < 4; k++) add_beat(1, 8'hB1 + k, KEEP_ALL, (k == 3));
    drive();
    for (int c = 0; c < 20 && !(m_tvalid && m_tdata == 8'hB2); c++) tick();
    check("t5_at_beat2", m_tdata, 8'hB2);
    rst = 1'b1;
    #1;
    check("t5_rst_mvalid", m_tvalid, 0);
    check("t5_rst_sready", s_tready, 0);
    check("t5_rst_mdata",  m_tdata, 0);
    add_beat(0, 8'hA0, KEEP_ALL, 1'b1);
    add_beat(3, 8'hD0, KEEP_ALL, 1'b1);
    drive();
    @(posedge clk);
    #1;
    check("t5_hold_sready", s_tready, 0);
    rst   = 1'b0;
    out_n = 0;
    drive();
    for (int c = 0; c < 40 && out_n < 4; c++) tick();
    check("t5_count", out_n, 4);
    check("t5_tid0",  out_id[0], 0);
    check("t5_data0", out_d[0], 8'hA0);
    check("t5_tid1",  out_id[1], 1);
    check("t5_data1", out_d[1], 8'hB3);
    check("t5_data2", out_d[2], 8'hB4);
    check("t5_last2", out_l[2], 1);
    check("t5_tid3",  out_id[3], 3);
    check("t5_data3", out_d[3], 8'hD0);

    // 6: must_read on a port with no tvalid does not win
    do_reset();
    m_tready  = 1'b1;
    must_read = 4'b1010;
    add_beat(2, 8'hE2, KEEP_ALL, 1'b1);
    add_beat(3, 8'hE3, KEEP_ALL, 1'b1);
    drive();
    for (int c = 0; c < 20 && out_n < 2; c++) tick();
    check("t6_count", out_n, 2);
    check("t6_tid0",  out_id[0], 3);
    check("t6_data0", out_d[0], 8'hE3);
    check("t6_tid1",  out_id[1], 2);
    check("t6_data1", out_d[1], 8'hE2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
